// File: rtl/gsm_cdc_pkg.sv
// Shared definitions for the GSM switch gray-pointer pulse-crossing channel.
//   st_e     : status encoding reported by the transmitter (IDLE/SEND/STALL)
//   bin2gray : binary to reflected-gray conversion, up to 16-bit pointers
package gsm_cdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } st_e;

  // Callers zero-extend narrower pointers and slice the result back down.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return (b >> 1) ^ b;
  endfunction

endpackage

// File: rtl/gsm_cdc_pulse_tx_if.sv
// Handshake/status bundle of the pulse-crossing transmitter.
//   ev_valid/ev_cnt/ev_ready : multi-count event request handshake
//   flush                    : discard all not-yet-issued events
//   rptr_async               : reader gray pointer (reader clock domain)
//   wptr                     : registered gray write pointer toward the reader
//   full/pending/st          : crossing-full flag, queued event count, status
// Modports: master = request source / reader side, slave = transmitter.
interface gsm_cdc_pulse_tx_if #(
  parameter int PTR_W  = 3,
  parameter int CNT_W  = 8,
  parameter int PEND_W = 10
);
  logic              ev_valid;
  logic [CNT_W-1:0]  ev_cnt;
  logic              ev_ready;
  logic              flush;
  logic [PTR_W-1:0]  rptr_async;
  logic [PTR_W-1:0]  wptr;
  logic              full;
  logic [PEND_W-1:0] pending;
  logic [1:0]        st;

  modport master (
    output ev_valid, ev_cnt, flush, rptr_async,
    input  ev_ready, wptr, full, pending, st
  );

  modport slave (
    input  ev_valid, ev_cnt, flush, rptr_async,
    output ev_ready, wptr, full, pending, st
  );
endinterface

// File: rtl/gsm_cdc_sync2.sv
// Two-flop vector synchronizer into the wclk domain. Only safe for
// gray-coded (single-bit-change) vectors; no logic sits between stages.
//   wclk, wrst_n : destination clock, synchronous active-low reset
//   d            : asynchronous input vector
//   q            : synchronized output (2 wclk latency)
module gsm_cdc_sync2 #(
  parameter int W = 3
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d, s1_q;
  logic [W-1:0] s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/gsm_cdc_pulse_tx.sv
// Write-side endpoint of the gray-pointer pulse-crossing channel.
// Accepts multi-count event requests into a pending accumulator and issues
// at most one event per wclk as a gray write-pointer increment, throttled
// by the synchronized reader pointer.
//   wclk, wrst_n : write clock, synchronous active-low reset
//   bus (slave)  : ev_valid/ev_cnt/ev_ready, flush, rptr_async, wptr, full,
//                  pending, st
//   sent_cnt     : (GSM_CDC_TX_STATS_EN) issued events, wraps
//   stall_cnt    : (GSM_CDC_TX_STATS_EN) cycles in STALL, saturates
// Optional feature macro: GSM_CDC_TX_STATS_EN
module gsm_cdc_pulse_tx
  import gsm_cdc_pkg::*;
#(
  parameter int PTR_W  = 3,
  parameter int CNT_W  = 8,
  parameter int PEND_W = 10
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  gsm_cdc_pulse_tx_if.slave    bus
`ifdef GSM_CDC_TX_STATS_EN
  ,
  output logic [15:0]          sent_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  // Largest pending count that can still absorb a maximal request.
  localparam logic [PEND_W-1:0] READY_MAX =
    PEND_W'((2**PEND_W - 1) - (2**CNT_W - 1));

  logic [PTR_W-1:0]  rq2;
  logic [PTR_W-1:0]  wbin_d, wbin_q;
  logic [PTR_W-1:0]  wptr_d, wptr_q;
  logic [PEND_W-1:0] pending_d, pending_q;
  logic [PTR_W-1:0]  wbin_inc;
  logic [PTR_W-1:0]  gray_inc;
  logic              full;
  logic              issue;
  logic              ev_ready;
  logic              accept;
  st_e               st;

  gsm_cdc_sync2 #(.W(PTR_W)) u_rptr_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (bus.rptr_async),
    .q      (rq2)
  );

  // Combinational decode from registered state
  always_comb begin
    wbin_inc = wbin_q + PTR_W'(1);
    gray_inc = PTR_W'(bin2gray(16'(wbin_inc)));
    // Next pointer would collide with the reader: all slots outstanding.
    full     = (gray_inc == rq2);
    issue    = (pending_q != '0) && !full && !bus.flush;
    ev_ready = !bus.flush && (pending_q <= READY_MAX);
    accept   = bus.ev_valid && ev_ready;

    if (pending_q == '0) st = ST_IDLE;
    else if (full)       st = ST_STALL;
    else                 st = ST_SEND;

    wbin_d    = issue ? wbin_inc : wbin_q;
    wptr_d    = issue ? gray_inc : wptr_q;
    // Flush drops queued events only; already-issued pointer moves stand.
    if (bus.flush)
      pending_d = '0;
    else
      pending_d = pending_q
                + (accept ? PEND_W'(bus.ev_cnt) : '0)
                - PEND_W'(issue);
  end

  // Pointer / accumulator registers
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      wbin_q    <= '0;
      wptr_q    <= '0;
      pending_q <= '0;
    end else begin
      wbin_q    <= wbin_d;
      wptr_q    <= wptr_d;
      pending_q <= pending_d;
    end
  end

  assign bus.wptr     = wptr_q;
  assign bus.full     = full;
  assign bus.pending  = pending_q;
  assign bus.ev_ready = ev_ready;
  assign bus.st       = st;

`ifdef GSM_CDC_TX_STATS_EN
  logic [15:0] sent_cnt_d, sent_cnt_q;
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    sent_cnt_d  = sent_cnt_q + 16'(issue);
    stall_cnt_d = stall_cnt_q;
    if (st == ST_STALL && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Statistics registers; flush intentionally leaves them alone
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      sent_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      sent_cnt_q  <= sent_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sent_cnt  = sent_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gsm_cdc_pulse_tx.sv
// Directed table-driven bench for gsm_cdc_pulse_tx (default parameters).
// Honors GSM_CDC_TX_STATS_EN to connect and check the statistics outputs.
module tb_gsm_cdc_pulse_tx;

  localparam int PTR_W  = 3;
  localparam int CNT_W  = 8;
  localparam int PEND_W = 10;
  localparam int NV     = 52;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  typedef struct {
    logic              rst_n;
    logic              ev_valid;
    logic [CNT_W-1:0]  ev_cnt;
    logic              flush;
    logic [PTR_W-1:0]  rptr;
    logic              chk;
    logic [PTR_W-1:0]  wptr;
    logic [PEND_W-1:0] pend;
    logic              full;
    logic              rdy;
    logic [1:0]        st;
  } vec_t;

  logic wclk;
  logic wrst_n;
  int   n_cmp;
  int   n_bad;
  vec_t tbl [NV];

  gsm_cdc_pulse_tx_if #(.PTR_W(PTR_W), .CNT_W(CNT_W), .PEND_W(PEND_W)) bus ();

`ifdef GSM_CDC_TX_STATS_EN
  logic [15:0] sent_cnt;
  logic [15:0] stall_cnt;
`endif

  gsm_cdc_pulse_tx #(.PTR_W(PTR_W), .CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .bus       (bus)
`ifdef GSM_CDC_TX_STATS_EN
    ,
    .sent_cnt  (sent_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic v(input int i, input logic rst_n, input logic evv,
                   input int cnt, input logic fl, input int rptr,
                   input logic chk, input int wptr, input int pend,
                   input logic full, input logic rdy, input logic [1:0] st);
    tbl[i].rst_n    = rst_n;
    tbl[i].ev_valid = evv;
    tbl[i].ev_cnt   = CNT_W'(cnt);
    tbl[i].flush    = fl;
    tbl[i].rptr     = PTR_W'(rptr);
    tbl[i].chk      = chk;
    tbl[i].wptr     = PTR_W'(wptr);
    tbl[i].pend     = PEND_W'(pend);
    tbl[i].full     = full;
    tbl[i].rdy      = rdy;
    tbl[i].st       = st;
  endtask

  task automatic check_outputs(input string tag, input int wptr, input int pend,
                               input logic full, input logic rdy, input logic [1:0] st);
    check({tag, "_wptr"},  int'(bus.wptr),     wptr);
    check({tag, "_pend"},  int'(bus.pending),  pend);
    check({tag, "_full"},  int'(bus.full),     int'(full));
    check({tag, "_ready"}, int'(bus.ev_ready), int'(rdy));
    check({tag, "_st"},    int'(bus.st),       int'(st));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wrst_n         = 1'b0;
    bus.ev_valid   = 1'b0;
    bus.ev_cnt     = '0;
    bus.flush      = 1'b0;
    bus.rptr_async = '0;

    //   i  rst ev cnt fl rp chk wptr pend full rdy st
    // reset, then loopback reader, ev_cnt=3
    v( 0, 0, 0,   0, 0, 0, 0,  0,   0, 0, 0, IDLE);
    v( 1, 0, 0,   0, 0, 0, 0,  0,   0, 0, 0, IDLE);
    v( 2, 1, 1,   3, 0, 0, 1,  0,   0, 0, 1, IDLE);
    v( 3, 1, 0,   0, 0, 0, 1,  0,   3, 0, 1, SEND);
    v( 4, 1, 0,   0, 0, 1, 1,  1,   2, 0, 1, SEND);
    v( 5, 1, 0,   0, 0, 3, 1,  3,   1, 0, 1, SEND);
    v( 6, 1, 0,   0, 0, 2, 1,  2,   0, 0, 1, IDLE);
    v( 7, 1, 0,   0, 0, 2, 1,  2,   0, 0, 1, IDLE);
    v( 8, 1, 0,   0, 0, 2, 1,  2,   0, 0, 1, IDLE);
    // accept 5 while issuing from pending=2 -> 6
    v( 9, 1, 1,   2, 0, 2, 1,  2,   0, 0, 1, IDLE);
    v(10, 1, 1,   5, 0, 2, 1,  2,   2, 0, 1, SEND);
    v(11, 1, 0,   0, 0, 2, 1,  6,   6, 0, 1, SEND);
    v(12, 1, 0,   0, 0, 2, 1,  7,   5, 0, 1, SEND);
    v(13, 1, 0,   0, 0, 2, 1,  5,   4, 0, 1, SEND);
    v(14, 1, 0,   0, 0, 2, 1,  4,   3, 0, 1, SEND);
    v(15, 1, 0,   0, 0, 2, 1,  0,   2, 0, 1, SEND);
    v(16, 1, 0,   0, 0, 2, 1,  1,   1, 0, 1, SEND);
    v(17, 1, 0,   0, 0, 3, 1,  3,   0, 1, 1, IDLE);
    v(18, 1, 0,   0, 0, 3, 1,  3,   0, 1, 1, IDLE);
    v(19, 1, 0,   0, 0, 3, 1,  3,   0, 0, 1, IDLE);
    // reset, reader stuck at 0, ev_cnt=10 -> 7 issues then STALL
    v(20, 0, 0,   0, 0, 0, 0,  0,   0, 0, 0, IDLE);
    v(21, 0, 0,   0, 0, 0, 0,  0,   0, 0, 0, IDLE);
    v(22, 1, 1,  10, 0, 0, 1,  0,   0, 0, 1, IDLE);
    v(23, 1, 0,   0, 0, 0, 1,  0,  10, 0, 1, SEND);
    v(24, 1, 0,   0, 0, 0, 1,  1,   9, 0, 1, SEND);
    v(25, 1, 0,   0, 0, 0, 1,  3,   8, 0, 1, SEND);
    v(26, 1, 0,   0, 0, 0, 1,  2,   7, 0, 1, SEND);
    v(27, 1, 0,   0, 0, 0, 1,  6,   6, 0, 1, SEND);
    v(28, 1, 0,   0, 0, 0, 1,  7,   5, 0, 1, SEND);
    v(29, 1, 0,   0, 0, 0, 1,  5,   4, 0, 1, SEND);
    v(30, 1, 0,   0, 0, 0, 1,  4,   3, 1, 1, STALL);
    v(31, 1, 0,   0, 0, 2, 1,  4,   3, 1, 1, STALL);
    v(32, 1, 0,   0, 0, 2, 1,  4,   3, 1, 1, STALL);
    v(33, 1, 0,   0, 0, 2, 1,  4,   3, 0, 1, SEND);
    v(34, 1, 0,   0, 0, 2, 1,  0,   2, 0, 1, SEND);
    v(35, 1, 0,   0, 0, 2, 1,  1,   1, 0, 1, SEND);
    v(36, 1, 0,   0, 0, 2, 1,  3,   0, 1, 1, IDLE);
    // flush with pending=20 and a valid request
    v(37, 1, 1,  20, 0, 2, 1,  3,   0, 1, 1, IDLE);
    v(38, 1, 1,   4, 1, 2, 1,  3,  20, 1, 0, STALL);
    v(39, 1, 0,   0, 0, 2, 1,  3,   0, 1, 1, IDLE);
    // ev_ready boundary at 768/769
    v(40, 1, 1, 255, 0, 2, 1,  3,   0, 1, 1, IDLE);
    v(41, 1, 1, 255, 0, 2, 1,  3, 255, 1, 1, STALL);
    v(42, 1, 1, 255, 0, 2, 1,  3, 510, 1, 1, STALL);
    v(43, 1, 1,   3, 0, 2, 1,  3, 765, 1, 1, STALL);
    v(44, 1, 1,   1, 0, 2, 1,  3, 768, 1, 1, STALL);
    v(45, 1, 1,   7, 0, 2, 1,  3, 769, 1, 0, STALL);
    v(46, 1, 0,   0, 0, 3, 1,  3, 769, 1, 0, STALL);
    v(47, 1, 0,   0, 0, 3, 1,  3, 769, 1, 0, STALL);
    v(48, 1, 0,   0, 0, 3, 1,  3, 769, 0, 0, SEND);
    v(49, 1, 0,   0, 0, 3, 1,  2, 768, 0, 1, SEND);
    // flush blocks an otherwise legal issue; wptr holds
    v(50, 1, 1,   5, 1, 3, 1,  6, 767, 0, 0, SEND);
    v(51, 1, 0,   0, 0, 3, 1,  6,   0, 0, 1, IDLE);

    for (int i = 0; i < NV; i++) begin
      @(negedge wclk);
      wrst_n         = tbl[i].rst_n;
      bus.ev_valid   = tbl[i].ev_valid;
      bus.ev_cnt     = tbl[i].ev_cnt;
      bus.flush      = tbl[i].flush;
      bus.rptr_async = tbl[i].rptr;
      #1;
      if (tbl[i].chk)
        check_outputs($sformatf("s%0d", i), int'(tbl[i].wptr), int'(tbl[i].pend),
                      tbl[i].full, tbl[i].rdy, tbl[i].st);
    end

`ifdef GSM_CDC_TX_STATS_EN
    // 12 issues and 11 STALL cycles since the reset at step 20
    check("stats_sent",  int'(sent_cnt),  12);
    check("stats_stall", int'(stall_cnt), 11);
`endif

    // Mid-operation reset drops pending events and rewinds the pointer
    @(negedge wclk);
    bus.ev_valid = 1'b1;
    bus.ev_cnt   = CNT_W'(5);
    @(negedge wclk);
    bus.ev_valid = 1'b0;
    wrst_n       = 1'b0;
    #1;
    check("pre_rst_pend", int'(bus.pending), 5);
    check("pre_rst_wptr", int'(bus.wptr),    6);
    @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    check_outputs("post_rst", 0, 0, 1'b0, 1'b1, IDLE);
`ifdef GSM_CDC_TX_STATS_EN
    check("post_rst_sent",  int'(sent_cnt),  0);
    check("post_rst_stall", int'(stall_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
